// File: rtl/spi_pwm_multi.sv
// SPI-configured multi-channel PWM: LSB-first frames load per-channel shadow registers, which become active at each period wrap.
// Latency: a committed frame applies at the channel's next pwm_cnt wrap. Backpressure: none (SPI has no stall); bad frames pulse cfg_err.
module spi_pwm_multi #(
  parameter int NUM_CH     = 4,
  parameter int DUTY_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_cs,
  output logic              spi_miso,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              cfg_err
);

  localparam int F  = 8 + DIV_WIDTH + DUTY_WIDTH;
  localparam int CW = $clog2(F + 2);
  localparam logic [CW-1:0] F_CNT    = CW'(F);
  localparam logic [CW-1:0] F_SAT    = CW'(F + 1);
  localparam logic [7:0]    NUM_CH_8 = 8'(NUM_CH);

  typedef struct packed {
    logic                  en;
    logic [DIV_WIDTH-1:0]  div;
    logic [DUTY_WIDTH-1:0] duty;
  } ch_cfg_t;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  logic [1:0]    sclk_s, mosi_s, cs_s;
  logic          sclk_d, cs_d;
  logic          sclk_rise, cs_fall, cs_rise;
  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [F-1:0]  shreg;
  logic [6:0]    idx;
  logic          idx_ok, commit_we;
  ch_cfg_t       frame_cfg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s   <= '0;
      mosi_s   <= '0;
      cs_s     <= '0;
      sclk_d   <= 1'b0;
      cs_d     <= 1'b0;
      spi_miso <= 1'b0;
    end else begin
      sclk_s   <= {sclk_s[0], spi_sclk};
      mosi_s   <= {mosi_s[0], spi_mosi};
      cs_s     <= {cs_s[0], spi_cs};
      sclk_d   <= sclk_s[1];
      cs_d     <= cs_s[1];
      spi_miso <= mosi_s[1];
    end
  end

  // cs_d resets low, so a cs held low through reset never looks like a fresh frame start
  assign sclk_rise = sclk_s[1] & ~sclk_d;
  assign cs_fall   = cs_d & ~cs_s[1];
  assign cs_rise   = cs_s[1] & ~cs_d;

  assign idx       = shreg[6:0];
  assign idx_ok    = {1'b0, idx} < NUM_CH_8;
  assign commit_we = (state == COMMIT) && idx_ok;

  always_comb begin
    frame_cfg      = '0;
    frame_cfg.en   = shreg[7];
    frame_cfg.div  = shreg[8 +: DIV_WIDTH];
    frame_cfg.duty = shreg[8 + DIV_WIDTH +: DUTY_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            if (bit_cnt == F_CNT) begin
              state <= COMMIT;
            end else begin
              cfg_err <= 1'b1;
              state   <= IDLE;
            end
          end else if (sclk_rise) begin
            // extra edges only push the count to F+1 so the frame is rejected at cs rise
            if (bit_cnt < F_CNT) begin
              shreg   <= {mosi_s[1], shreg[F-1:1]};
              bit_cnt <= bit_cnt + CW'(1);
            end else begin
              bit_cnt <= F_SAT;
            end
          end
        end
        COMMIT: begin
          if (!idx_ok) cfg_err <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_cfg_t               shadow, active;
    logic [DIV_WIDTH-1:0]  div_cnt;
    logic [DUTY_WIDTH-1:0] pwm_cnt;
    logic                  tick, pwm_q;

    assign tick = (div_cnt == active.div);

    always_ff @(posedge clk) begin
      if (rst) begin
        shadow  <= '0;
        active  <= '0;
        div_cnt <= '0;
        pwm_cnt <= '0;
        pwm_q   <= 1'b0;
      end else begin
        if (commit_we && (idx == 7'(i))) shadow <= frame_cfg;
        if (tick) begin
          div_cnt <= '0;
          pwm_cnt <= pwm_cnt + DUTY_WIDTH'(1);
          if (&pwm_cnt) active <= shadow;
        end else begin
          div_cnt <= div_cnt + DIV_WIDTH'(1);
        end
        pwm_q <= active.en && (pwm_cnt < active.duty);
      end
    end

    assign pwm_out[i] = pwm_q;
  end

endmodule

// File: tb/tb_spi_pwm_multi.sv
// Directed bench for spi_pwm_multi: SPI frames in, PWM high/low run lengths and cfg_err pulses checked.
module tb_spi_pwm_multi;

  logic       clk = 1'b0, rst = 1'b1;
  logic       spi_sclk = 1'b0, spi_mosi = 1'b0, spi_cs = 1'b1;
  logic       spi_miso, cfg_err;
  logic [3:0] pwm_out;

  int checks = 0, failures = 0;
  int err_cnt = 0;
  int mon_ch = 0;
  int hi_q[$], lo_q[$];
  int hi_run = 0, lo_run = 0;

  always #5 clk = ~clk;

  spi_pwm_multi #(.NUM_CH(4), .DUTY_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
    .spi_miso(spi_miso), .pwm_out(pwm_out), .cfg_err(cfg_err)
  );

  // run-length recorder for the monitored channel
  always @(negedge clk) begin
    if (cfg_err === 1'b1) err_cnt++;
    if (pwm_out[mon_ch] === 1'b1) begin
      hi_run++;
      if (lo_run != 0) begin lo_q.push_back(lo_run); lo_run = 0; end
    end else begin
      lo_run++;
      if (hi_run != 0) begin hi_q.push_back(hi_run); hi_run = 0; end
    end
  end

  function automatic logic [31:0] mk(input logic [6:0] idx, input logic en,
                                     input logic [15:0] dv, input logic [7:0] dt);
    return {dt, dv, en, idx};
  endfunction

  task automatic send_bits(input logic [31:0] fr, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      spi_mosi = (i < 32) ? fr[i] : 1'b0;
      #20 spi_sclk = 1'b1;
      #20 spi_sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] fr, input int n);
    @(negedge clk);
    spi_cs = 1'b0;
    #40;
    send_bits(fr, 0, n);
    #40 spi_cs = 1'b1;
    #80;
  endtask

  task automatic measure(input int ch, output int hi, output int lo);
    int t;
    mon_ch = ch;
    hi_q.delete();
    lo_q.delete();
    t = 0;
    while ((hi_q.size() < 2 || lo_q.size() < 2) && t < 6000) begin
      @(negedge clk);
      t++;
    end
    if (hi_q.size() >= 2 && lo_q.size() >= 2) begin
      hi = hi_q[1];
      lo = lo_q[1];
    end else begin
      hi = -1;
      lo = -1;
    end
  endtask

  task automatic count_high(input int ch, input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pwm_out[ch] !== 1'b0) cnt++;
    end
  endtask

  task automatic test_reset();
    int c;
    rst = 1'b1;
    spi_mosi = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (pwm_out !== 4'b0) begin failures++; $display("FAIL reset_pwm: got %b expected 0000", pwm_out); end
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err: got %b expected 0", cfg_err); end
    checks++; if (spi_miso !== 1'b0) begin failures++; $display("FAIL reset_miso: got %b expected 0", spi_miso); end
    spi_mosi = 1'b0;
    rst = 1'b0;
    c = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pwm_out !== 4'b0) c++;
    end
    checks++; if (c != 0) begin failures++; $display("FAIL idle_low: got %0d high cycles expected 0", c); end
  endtask

  task automatic test_miso();
    spi_mosi = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (spi_miso !== 1'b1) begin failures++; $display("FAIL miso_hi: got %b expected 1", spi_miso); end
    spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (spi_miso !== 1'b0) begin failures++; $display("FAIL miso_lo: got %b expected 0", spi_miso); end
  endtask

  task automatic test_valid_ch1();
    int hi, lo, c;
    send_frame(mk(7'd1, 1'b1, 16'd0, 8'd64), 32);
    measure(1, hi, lo);
    checks++; if (hi != 64) begin failures++; $display("FAIL ch1_high: got %0d expected 64", hi); end
    checks++; if (lo != 192) begin failures++; $display("FAIL ch1_low: got %0d expected 192", lo); end
    checks++; if (err_cnt != 0) begin failures++; $display("FAIL ch1_no_err: got %0d expected 0", err_cnt); end
    for (int ch = 0; ch < 4; ch++) begin
      if (ch != 1) begin
        count_high(ch, 300, c);
        checks++; if (c != 0) begin failures++; $display("FAIL ch1_others_low ch%0d: got %0d expected 0", ch, c); end
      end
    end
  endtask

  task automatic test_short_frame();
    int e0, hi, lo, c;
    e0 = err_cnt;
    send_frame(mk(7'd3, 1'b1, 16'd0, 8'd200), 31);
    repeat (10) @(negedge clk);
    checks++; if (err_cnt != e0 + 1) begin failures++; $display("FAIL short_err: got %0d expected %0d", err_cnt, e0 + 1); end
    count_high(3, 600, c);
    checks++; if (c != 0) begin failures++; $display("FAIL short_ch3: got %0d expected 0", c); end
    measure(1, hi, lo);
    checks++; if (hi != 64) begin failures++; $display("FAIL short_ch1: got %0d expected 64", hi); end
  endtask

  task automatic test_long_frame();
    int e0, c;
    e0 = err_cnt;
    send_frame(mk(7'd3, 1'b1, 16'd0, 8'd200), 33);
    repeat (10) @(negedge clk);
    checks++; if (err_cnt != e0 + 1) begin failures++; $display("FAIL long_err: got %0d expected %0d", err_cnt, e0 + 1); end
    count_high(3, 600, c);
    checks++; if (c != 0) begin failures++; $display("FAIL long_ch3: got %0d expected 0", c); end
  endtask

  task automatic test_bad_index();
    int e0, hi, lo, c;
    e0 = err_cnt;
    send_frame(mk(7'd9, 1'b1, 16'd0, 8'd200), 32);
    repeat (10) @(negedge clk);
    checks++; if (err_cnt != e0 + 1) begin failures++; $display("FAIL idx_err: got %0d expected %0d", err_cnt, e0 + 1); end
    measure(1, hi, lo);
    checks++; if (hi != 64) begin failures++; $display("FAIL idx_ch1: got %0d expected 64", hi); end
    count_high(3, 300, c);
    checks++; if (c != 0) begin failures++; $display("FAIL idx_ch3: got %0d expected 0", c); end
  endtask

  task automatic test_rewrite();
    int hi, lo, n, m, t, e0;
    e0 = err_cnt;
    send_frame(mk(7'd0, 1'b1, 16'd1, 8'd128), 32);
    measure(0, hi, lo);
    checks++; if (hi != 256) begin failures++; $display("FAIL rw_first_high: got %0d expected 256", hi); end
    checks++; if (lo != 256) begin failures++; $display("FAIL rw_first_low: got %0d expected 256", lo); end
    n = lo_q.size();
    t = 0;
    while (lo_q.size() <= n && t < 2000) begin @(negedge clk); t++; end
    m = hi_q.size();
    send_frame(mk(7'd0, 1'b1, 16'd1, 8'd32), 32);
    t = 0;
    while (hi_q.size() < m + 2 && t < 3000) begin @(negedge clk); t++; end
    if (hi_q.size() >= m + 2) begin
      checks++; if (hi_q[m] != 256) begin failures++; $display("FAIL rw_cur_period: got %0d expected 256", hi_q[m]); end
      checks++; if (hi_q[m+1] != 64) begin failures++; $display("FAIL rw_next_period: got %0d expected 64", hi_q[m+1]); end
    end else begin
      checks++; failures++;
      $display("FAIL rw_timeout: got %0d runs expected %0d", hi_q.size(), m + 2);
    end
    checks++; if (err_cnt != e0) begin failures++; $display("FAIL rw_no_err: got %0d expected %0d", err_cnt, e0); end
  endtask

  task automatic test_div3();
    int hi, lo;
    send_frame(mk(7'd2, 1'b1, 16'd3, 8'd255), 32);
    measure(2, hi, lo);
    checks++; if (hi != 1020) begin failures++; $display("FAIL div3_high: got %0d expected 1020", hi); end
    checks++; if (lo != 4) begin failures++; $display("FAIL div3_low: got %0d expected 4", lo); end
  endtask

  task automatic test_rst_mid_frame();
    logic [31:0] fr;
    int e0, hi, lo, c;
    fr = mk(7'd2, 1'b1, 16'd0, 8'd100);
    e0 = err_cnt;
    @(negedge clk);
    spi_cs = 1'b0;
    #40;
    send_bits(fr, 0, 20);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (pwm_out !== 4'b0) begin failures++; $display("FAIL rstmid_pwm: got %b expected 0000", pwm_out); end
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL rstmid_cfg_err: got %b expected 0", cfg_err); end
    rst = 1'b0;
    send_bits(fr, 20, 12);
    #40 spi_cs = 1'b1;
    #80;
    repeat (10) @(negedge clk);
    checks++; if (err_cnt != e0) begin failures++; $display("FAIL rstmid_no_err: got %0d expected %0d", err_cnt, e0); end
    count_high(2, 600, c);
    checks++; if (c != 0) begin failures++; $display("FAIL rstmid_ch2: got %0d expected 0", c); end
    send_frame(mk(7'd3, 1'b1, 16'd0, 8'd16), 32);
    measure(3, hi, lo);
    checks++; if (hi != 16) begin failures++; $display("FAIL rstmid_ch3_high: got %0d expected 16", hi); end
    checks++; if (lo != 240) begin failures++; $display("FAIL rstmid_ch3_low: got %0d expected 240", lo); end
    checks++; if (err_cnt != e0) begin failures++; $display("FAIL rstmid_after_err: got %0d expected %0d", err_cnt, e0); end
  endtask

  initial begin
    test_reset();
    test_miso();
    test_valid_ch1();
    test_short_frame();
    test_long_frame();
    test_bad_index();
    test_rewrite();
    test_div3();
    test_rst_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
